// File: rtl/grid_scanout.sv
// grid_scanout: reader side of the life-grid cell array.
// Captures one generation snapshot of the flattened grid and streams it out
// one row per valid/ready beat, then reports the frame's population and
// whether it differs from the previous frame. Snapshots offered while a
// frame is still streaming are dropped and counted as overruns.
//
// Ports:
//   clk, _rst          clock (rising edge), async active-low reset
//   grid_flat          cell states, bit r*COLS+c = cell (r,c)
//   gen_tick           one-cycle pulse: grid_flat holds a settled generation
//   out_ready          consumer accepts the current beat
//   out_valid          row beat valid
//   out_row_idx        row index of the current beat
//   out_row_data       cells of that row, bit c = column c
//   out_last           high on the row ROWS-1 beat
//   frame_done         one-cycle pulse after the final beat is accepted
//   pop_total          live-cell count of the last completed frame
//   changed            last completed frame differs from the one before
//   gen_count          snapshots accepted since reset (wraps)
//   drop_count         dropped gen_ticks, saturating at 255
//   overrun            sticky drop flag
//   clr_overrun        clears overrun and drop_count
module grid_scanout #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16,
  parameter int POP_W = 7
) (
  input  logic                 clk,
  input  logic                 _rst,
  input  logic [ROWS*COLS-1:0] grid_flat,
  input  logic                 gen_tick,
  input  logic                 out_ready,
  input  logic                 clr_overrun,
  output logic                 out_valid,
  output logic [2:0]           out_row_idx,
  output logic [COLS-1:0]      out_row_data,
  output logic                 out_last,
  output logic                 frame_done,
  output logic [POP_W-1:0]     pop_total,
  output logic                 changed,
  output logic [GEN_W-1:0]     gen_count,
  output logic [7:0]           drop_count,
  output logic                 overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state, state_nxt;
  logic [ROWS*COLS-1:0] snapshot, prev_snap;
  logic [2:0]           row;
  logic [POP_W-1:0]     acc;
  logic [POP_W-1:0]     row_pop;
  logic                 hs, last_hs, accept, drop;

  function automatic logic [POP_W-1:0] popcount(input logic [COLS-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < COLS; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

  assign hs      = out_valid && out_ready;
  assign last_hs = hs && out_last;
  // A tick is taken when idle, or on the very edge the current frame ends,
  // so back-to-back frames stream with no idle gap.
  assign accept  = gen_tick && ((state == IDLE) || last_hs);
  assign drop    = gen_tick && !accept;
  assign row_pop = popcount(out_row_data);

  // State register
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (gen_tick) state_nxt = SEND;
      SEND: if (last_hs)  state_nxt = gen_tick ? SEND : IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  // Beat outputs, all derived from registered state
  always_comb begin
    out_valid    = 1'b0;
    out_row_idx  = '0;
    out_row_data = '0;
    out_last     = 1'b0;
    if (state == SEND) begin
      out_valid    = 1'b1;
      out_row_idx  = row;
      out_row_data = snapshot[row*COLS +: COLS];
      out_last     = (row == 3'(ROWS-1));
    end
  end

  // Snapshot capture and row walk
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      snapshot  <= '0;
      prev_snap <= '0;
      row       <= '0;
      acc       <= '0;
      gen_count <= '0;
    end else if (accept) begin
      snapshot  <= grid_flat;
      prev_snap <= snapshot;
      row       <= '0;
      acc       <= '0;
      gen_count <= gen_count + 1'b1;
    end else if (hs) begin
      acc <= acc + row_pop;
      if (!out_last) row <= row + 1'b1;
    end
  end

  // Per-frame results; these use the finishing frame's snapshot even when a
  // new one loads on the same edge.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      frame_done <= 1'b0;
      pop_total  <= '0;
      changed    <= 1'b0;
    end else begin
      frame_done <= last_hs;
      if (last_hs) begin
        pop_total <= acc + row_pop;
        changed   <= (snapshot != prev_snap);
      end
    end
  end

  // Overrun tracking; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      drop_count <= '0;
      overrun    <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (clr_overrun)              drop_count <= 8'd1;
      else if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end else if (clr_overrun) begin
      drop_count <= '0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_grid_scanout.sv
// Directed bench for grid_scanout: glider frames, repeat frame, back-pressure,
// overrun counting/saturation/clear, back-to-back frames and mid-frame reset.
module tb_grid_scanout;

  localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402;
  localparam logic [63:0] GRID_B = 64'hFF00_0000_0000_0081;
  localparam logic [63:0] ONES   = {64{1'b1}};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] grid_flat;
  logic        gen_tick, out_ready, clr_overrun;
  logic        out_valid, out_last, frame_done, changed, overrun;
  logic [2:0]  out_row_idx;
  logic [7:0]  out_row_data, drop_count;
  logic [6:0]  pop_total;
  logic [15:0] gen_count;

  int nchk = 0;
  int npass = 0;

  always #5 clk = ~clk;

  grid_scanout dut (
    .clk(clk), ._rst(rst_n), .grid_flat(grid_flat), .gen_tick(gen_tick),
    .out_ready(out_ready), .clr_overrun(clr_overrun), .out_valid(out_valid),
    .out_row_idx(out_row_idx), .out_row_data(out_row_data), .out_last(out_last),
    .frame_done(frame_done), .pop_total(pop_total), .changed(changed),
    .gen_count(gen_count), .drop_count(drop_count), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Check beats for rows [from, to) with out_ready high, advancing one edge each.
  task automatic stream(input logic [63:0] g, input int from, input int to);
    for (int r = from; r < to; r++) begin
      chk($sformatf("valid_r%0d", r), 64'(out_valid), 64'd1);
      chk($sformatf("idx_r%0d", r), 64'(out_row_idx), 64'(r));
      chk($sformatf("data_r%0d", r), 64'(out_row_data), 64'(g[r*8 +: 8]));
      chk($sformatf("last_r%0d", r), 64'(out_last), 64'(r == 7));
      cyc();
    end
  endtask

  task automatic frame_end(input int pop, input int chg, input int gen);
    chk("frame_done", 64'(frame_done), 64'd1);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("pop_total", 64'(pop_total), 64'(pop));
    chk("changed", 64'(changed), 64'(chg));
    chk("gen_count", 64'(gen_count), 64'(gen));
    cyc();
    chk("frame_done_pulse", 64'(frame_done), 64'd0);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_valid"}, 64'(out_valid), 64'd0);
    chk({pfx, "_idx"}, 64'(out_row_idx), 64'd0);
    chk({pfx, "_data"}, 64'(out_row_data), 64'd0);
    chk({pfx, "_last"}, 64'(out_last), 64'd0);
    chk({pfx, "_done"}, 64'(frame_done), 64'd0);
    chk({pfx, "_pop"}, 64'(pop_total), 64'd0);
    chk({pfx, "_changed"}, 64'(changed), 64'd0);
    chk({pfx, "_gen"}, 64'(gen_count), 64'd0);
    chk({pfx, "_drop"}, 64'(drop_count), 64'd0);
    chk({pfx, "_overrun"}, 64'(overrun), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; grid_flat = '0; gen_tick = 1'b0; out_ready = 1'b0; clr_overrun = 1'b0;
    cyc(); cyc();
    chk_all_zero("reset");
    rst_n = 1'b1;
    cyc();

    // Frame 1: glider, first compare against all-zero history
    grid_flat = GLIDER; gen_tick = 1'b1; out_ready = 1'b1;
    cyc();
    gen_tick = 1'b0;
    stream(GLIDER, 0, 8);
    frame_end(5, 1, 1);

    // Frame 2: same grid -> unchanged
    gen_tick = 1'b1;
    cyc();
    gen_tick = 1'b0;
    stream(GLIDER, 0, 8);
    frame_end(5, 0, 2);

    // Frame 3: back-pressure on row 2 for three cycles
    gen_tick = 1'b1;
    cyc();
    gen_tick = 1'b0;
    stream(GLIDER, 0, 2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_idx", 64'(out_row_idx), 64'd2);
      chk("stall_data", 64'(out_row_data), 64'h07);
    end
    out_ready = 1'b1;
    stream(GLIDER, 2, 8);
    frame_end(5, 0, 3);

    // Frame 4: three ticks during rows 1-3 are dropped
    gen_tick = 1'b1;
    cyc();
    gen_tick = 1'b0;
    stream(GLIDER, 0, 1);
    gen_tick = 1'b1;
    stream(GLIDER, 1, 4);
    gen_tick = 1'b0;
    chk("drop3_count", 64'(drop_count), 64'd3);
    chk("drop3_overrun", 64'(overrun), 64'd1);
    stream(GLIDER, 4, 8);
    frame_end(5, 0, 4);
    clr_overrun = 1'b1;
    cyc();
    clr_overrun = 1'b0;
    chk("clr_count", 64'(drop_count), 64'd0);
    chk("clr_overrun", 64'(overrun), 64'd0);

    // Frame 5: 300 drops while stalled on row 0 saturate the counter
    gen_tick = 1'b1; out_ready = 1'b0;
    cyc();
    repeat (300) cyc();
    gen_tick = 1'b0;
    chk("sat_count", 64'(drop_count), 64'd255);
    chk("sat_overrun", 64'(overrun), 64'd1);
    chk("sat_idx", 64'(out_row_idx), 64'd0);
    chk("sat_gen", 64'(gen_count), 64'd5);
    clr_overrun = 1'b1; gen_tick = 1'b1;
    cyc();
    gen_tick = 1'b0;
    chk("clr_vs_drop_count", 64'(drop_count), 64'd1);
    chk("clr_vs_drop_overrun", 64'(overrun), 64'd1);
    cyc();
    clr_overrun = 1'b0;
    chk("clr2_count", 64'(drop_count), 64'd0);
    chk("clr2_overrun", 64'(overrun), 64'd0);
    out_ready = 1'b1;
    stream(GLIDER, 0, 8);
    frame_end(5, 0, 5);

    // Frame 6 -> 7: grid changes mid-frame are ignored; tick on last handshake
    gen_tick = 1'b1;
    cyc();
    gen_tick = 1'b0;
    stream(GLIDER, 0, 3);
    grid_flat = GRID_B;
    stream(GLIDER, 3, 7);
    gen_tick = 1'b1;
    stream(GLIDER, 7, 8);
    gen_tick = 1'b0;
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_idx", 64'(out_row_idx), 64'd0);
    chk("b2b_data", 64'(out_row_data), 64'h81);
    chk("b2b_done", 64'(frame_done), 64'd1);
    chk("b2b_pop", 64'(pop_total), 64'd5);
    chk("b2b_changed", 64'(changed), 64'd0);
    chk("b2b_gen", 64'(gen_count), 64'd7);
    chk("b2b_drop", 64'(drop_count), 64'd0);
    chk("b2b_overrun", 64'(overrun), 64'd0);
    cyc();
    chk("b2b_done_pulse", 64'(frame_done), 64'd0);
    stream(GRID_B, 1, 8);
    frame_end(10, 1, 7);

    // Frame 8 aborted by reset during row 4
    grid_flat = GLIDER; gen_tick = 1'b1;
    cyc();
    gen_tick = 1'b0;
    stream(GLIDER, 0, 4);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    cyc();
    chk("midrst_no_done", 64'(frame_done), 64'd0);
    rst_n = 1'b1;

    // Fresh frame after reset: all ones
    grid_flat = ONES; gen_tick = 1'b1;
    cyc();
    gen_tick = 1'b0;
    chk("post_rst_gen", 64'(gen_count), 64'd1);
    stream(ONES, 0, 8);
    frame_end(64, 1, 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/grid_scanout.md
Name: grid_scanout

Overview:
- Reader side of the life-grid cell array: captures a generation snapshot of the flattened grid and streams it out one row per valid/ready beat.
- Also reports population and a changed/still-life indicator per generation.
- Sits between the cell matrix and downstream display or host logic.
- Decouples the matrix step rate from consumer back-pressure; snapshots arriving while busy are counted as overruns.

Parameters:
- ROWS, 8, grid rows.
- COLS, 8, grid columns; equals the row beat width.
- GEN_W, 16, generation counter width.
- POP_W, 7, population width; must hold ROWS*COLS.

Ports:
- clk  in  1  clock, rising edge.
- _rst  in  1  reset, asynchronous, active-low.
- grid_flat  in  ROWS*COLS  cell states; bit r*COLS+c = cell (r,c).
- gen_tick  in  1  one-cycle pulse: grid_flat holds a new, settled generation.
- out_ready  in  1  consumer accepts the current beat.
- out_valid  out  1  row beat valid.
- out_row_idx  out  3  row index of the current beat.
- out_row_data  out  COLS  cells of that row; bit c = column c.
- out_last  out  1  high with the row ROWS-1 beat.
- frame_done  out  1  one-cycle pulse after the final beat is accepted.
- pop_total  out  POP_W  live-cell count of the last completed frame.
- changed  out  1  last completed frame differs from the previous frame.
- gen_count  out  GEN_W  snapshots accepted since reset; wraps.
- drop_count  out  8  gen_ticks dropped; saturates at 255.
- overrun  out  1  sticky; set on any drop.
- clr_overrun  in  1  clears overrun and drop_count.

Behaviour:
- Reset (_rst low, asynchronous): state IDLE; snapshot, prev_snap, row counter, pop accumulator all 0; every output 0.
- State IDLE: out_valid=0. gen_tick=1 causes, on the next edge:
  - snapshot<=grid_flat; prev_snap<=snapshot; row<=0; acc<=0; gen_count++; state SEND.
- State SEND:
  - out_valid=1; out_row_idx=row; out_row_data=snapshot[row*COLS +: COLS]; out_last=(row==ROWS-1).
  - All outputs are registered or derived from registered state, and stay stable while out_valid && !out_ready.
- Handshake (out_valid && out_ready):
  - acc += popcount(out_row_data).
  - If not last: row++.
  - If last: pop_total <= acc + popcount(row); changed <= (snapshot != prev_snap); frame_done pulses next cycle; state IDLE.
- Latency:
  - gen_tick at cycle N -> row 0 valid at N+1.
  - With out_ready held high, the frame occupies N+1..N+ROWS and frame_done is at N+ROWS+1.
- gen_tick while busy:
  - In SEND and not on the final handshake cycle: tick dropped; drop_count++ (saturate at 255); overrun<=1; snapshot untouched.
  - On the final handshake cycle: tick accepted. New snapshot loads, state stays SEND, row<=0, next cycle shows row 0 of the new frame. frame_done and pop_total still report the finishing frame.
- clr_overrun together with a drop in the same cycle: the drop wins (overrun=1, drop_count=1).
- First frame after reset compares against an all-zero prev_snap.
- _rst asserted mid-frame: immediate return to reset values; the partial frame is discarded and no frame_done is issued.
- gen_count wraps modulo 2^GEN_W. pop_total is exact (0..64).
- grid_flat is sampled only on the accepting edge; changes at other times are ignored.

Test Plan:
- Glider at (0,1),(1,2),(2,0),(2,1),(2,2); gen_tick; out_ready=1 -> beats:
  - row0=8'h02, row1=8'h04, row2=8'h07, rows3-7=8'h00; out_last on row 7.
  - frame_done one cycle later; pop_total=5, changed=1, gen_count=1.
- Same grid ticked again -> changed=0, pop_total=5, gen_count=2.
- Back-pressure: out_ready low for 3 cycles on row 2 -> out_row_idx=2 and data 8'h07 held stable; no row skipped; pop_total=5.
- Overrun:
  - 3 gen_ticks during SEND rows 1-3 -> drop_count=3, overrun=1, streamed data unchanged.
  - clr_overrun -> both 0.
  - 300 drops -> drop_count=255.
- gen_tick coincident with the row 7 handshake:
  - next cycle out_valid=1, out_row_idx=0 with the new grid.
  - frame_done pulses for the old frame; no drop counted.
- _rst pulsed low mid-row 4 -> all outputs 0 within the cycle; next gen_tick starts from row 0 with gen_count=1; all-ones grid -> pop_total=64.
